// File: rtl/ks_noise_bank.sv
// ks_noise_bank: multi-channel excitation source for Karplus-Strong voices.
// Each channel owns a 24-bit XNOR LFSR. The LFSR advances 24 shifts per audio
// sample (one lrck rising edge). Its top WIDTH bits, arithmetically shifted
// right by `level`, form a signed noise sample. A channel outputs either
// continuous noise (mode=0) or noise gated by a counted burst (mode=1). A burst
// is started or restarted by that channel's trig bit.
//
// Ports:
//   lrck       sample clock (one rising edge per audio sample)
//   rst        asynchronous active-high reset
//   trig       per-channel pluck trigger
//   burst_len  burst length in samples, captured when a trigger is taken
//   mode       0 = continuous noise, 1 = burst-gated noise
//   level      attenuation shift (0..7)
//   seed_load  reload every LFSR from `seed` (replaces that edge's step)
//   seed       seed value used by seed_load
//   out        signed samples, channel i at [i*WIDTH +: WIDTH]
//   active     burst in progress per channel
//   done       one-cycle pulse when a burst ends
module ks_noise_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned LEN_W    = 12,
  parameter logic [23:0] SEED     = 24'h000000
) (
  input  logic                      lrck,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       trig,
  input  logic [LEN_W-1:0]          burst_len,
  input  logic                      mode,
  input  logic [2:0]                level,
  input  logic                      seed_load,
  input  logic [23:0]               seed,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       active,
  output logic [CHANNELS-1:0]       done
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [23:0] TAPS = 24'h80000D;

  // 24 unrolled XNOR-feedback shifts: one audio sample's worth of advance.
  function automatic logic [23:0] step24(input logic [23:0] s);
    logic [23:0] r;
    r = s;
    for (int unsigned k = 0; k < 24; k++) begin
      r = {r[22:0], ~^(r & TAPS)};
    end
    return r;
  endfunction

  // Per-channel seed; the all-ones XNOR lockup state is mapped to zero.
  function automatic logic [23:0] chan_seed(input int unsigned ch, input logic [23:0] x);
    logic [23:0] r;
    r = x ^ 24'(ch << 16);
    if (r == 24'hFFFFFF) begin
      r = '0;
    end
    return r;
  endfunction

  logic [23:0]               lfsr_q  [CHANNELS];
  logic [23:0]               lfsr_d  [CHANNELS];
  state_t                    state_q [CHANNELS];
  state_t                    state_d [CHANNELS];
  logic [LEN_W-1:0]          cnt_q   [CHANNELS];
  logic [LEN_W-1:0]          cnt_d   [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] out_q, out_d;
  logic [CHANNELS-1:0]       done_q, done_d;

  always_comb begin
    logic                    go;
    logic signed [WIDTH-1:0] samp;
    go     = 1'b0;
    samp   = '0;
    out_d  = '0;
    done_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      lfsr_d[i]  = seed_load ? chan_seed(i, seed) : step24(lfsr_q[i]);
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      // A zero-length trigger is ignored; a valid one (re)loads the count.
      go = trig[i] && (burst_len != '0);
      if (go) begin
        state_d[i] = BURST;
        cnt_d[i]   = burst_len;
      end else if (state_q[i] == BURST) begin
        if (cnt_q[i] <= LEN_W'(1)) begin
          state_d[i] = IDLE;
          done_d[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - LEN_W'(1);
        end
      end

      // Sample is taken from the LFSR value being written on this edge.
      samp = $signed(lfsr_d[i][23 -: WIDTH]) >>> level;
      if (!mode || state_d[i] == BURST) begin
        out_d[i*WIDTH +: WIDTH] = samp;
      end
    end
  end

  always_ff @(posedge lrck or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        lfsr_q[i]  <= chan_seed(i, SEED);
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      out_q  <= '0;
      done_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        lfsr_q[i]  <= lfsr_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      active[i] = (state_q[i] == BURST);
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_ks_noise_bank.sv
// Testbench for ks_noise_bank with 2 channels and 16-bit samples.
// A behavioural model of the LFSRs and burst FSMs pushes the expected
// {out, active, done} for every driven edge. Each test task pops that entry
// after the edge and compares it against the DUT.
`timescale 1ns/1ps
module tb_ks_noise_bank;

  localparam int          CH   = 2;
  localparam int          W    = 16;
  localparam int          LW   = 12;
  localparam logic [23:0] SEED = 24'h000000;

  logic              lrck = 1'b0;
  logic              rst  = 1'b1;
  logic [CH-1:0]     trig = '0;
  logic [LW-1:0]     burst_len = '0;
  logic              mode = 1'b0;
  logic [2:0]        level = '0;
  logic              seed_load = 1'b0;
  logic [23:0]       seed = '0;
  logic [CH*W-1:0]   out;
  logic [CH-1:0]     active;
  logic [CH-1:0]     done;

  ks_noise_bank #(.CHANNELS(CH), .WIDTH(W), .LEN_W(LW), .SEED(SEED)) dut (
    .lrck(lrck), .rst(rst), .trig(trig), .burst_len(burst_len), .mode(mode),
    .level(level), .seed_load(seed_load), .seed(seed), .out(out),
    .active(active), .done(done)
  );

  always #5 lrck = ~lrck;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [CH*W-1:0] o;
    logic [CH-1:0]   a;
    logic [CH-1:0]   d;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [35:0] obs;
  assign obs = {out, active, done};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [23:0] m_lfsr [CH];
  bit          m_busy [CH];
  int          m_cnt  [CH];

  function automatic logic [23:0] m_step(input logic [23:0] s);
    logic [23:0] r;
    r = s;
    for (int k = 0; k < 24; k++) r = {r[22:0], ~(r[23] ^ r[3] ^ r[2] ^ r[0])};
    return r;
  endfunction

  function automatic logic [23:0] m_cs(input int ch, input logic [23:0] x);
    logic [23:0] r;
    r = x ^ (24'(ch) << 16);
    if (r == 24'hFFFFFF) r = 24'h000000;
    return r;
  endfunction

  task automatic m_reset;
    for (int i = 0; i < CH; i++) begin
      m_lfsr[i] = m_cs(i, SEED);
      m_busy[i] = 0;
      m_cnt[i]  = 0;
    end
    sb.delete();
  endtask

  // Drive one edge's inputs, push the model's prediction, and advance past the edge.
  task automatic edge_drive(input logic [CH-1:0] t, input logic [LW-1:0] bl, input logic md,
                            input logic [2:0] lv, input logic sl, input logic [23:0] sd);
    exp_t x;
    logic signed [15:0] s16;
    trig = t; burst_len = bl; mode = md; level = lv; seed_load = sl; seed = sd;
    x = '0;
    for (int i = 0; i < CH; i++) begin
      m_lfsr[i] = sl ? m_cs(i, sd) : m_step(m_lfsr[i]);
      if (t[i] && bl != 0) begin
        m_busy[i] = 1; m_cnt[i] = int'(bl);
      end else if (m_busy[i]) begin
        if (m_cnt[i] == 1) begin m_busy[i] = 0; x.d[i] = 1'b1; end
        else m_cnt[i]--;
      end
      s16 = m_lfsr[i][23:8];
      s16 = s16 >>> lv;
      x.a[i] = m_busy[i];
      x.o[i*W +: W] = (!md || m_busy[i]) ? s16 : 16'sd0;
    end
    sb.push_back(x);
    @(posedge lrck); #1;
    trig = '0; seed_load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge lrck); @(posedge lrck); #1;
    n_cmp++;
    if (obs !== 36'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", obs, 36'h0);
    end
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_continuous;
    for (int k = 0; k < 1000; k++) begin
      edge_drive('0, '0, 1'b0, 3'd0, 1'b0, '0);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL continuous[%0d]: got %h want %h", k, obs, e);
      end
    end
  endtask

  task automatic test_burst;
    int act_n = 0, done_n = 0, done_at = -1;
    bit ch1_bad = 0;
    for (int k = 0; k < 8; k++) begin
      edge_drive(k == 0 ? 2'b01 : 2'b00, 12'd5, 1'b1, 3'd0, 1'b0, '0);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL burst[%0d]: got %h want %h", k, obs, e);
      end
      if (active[0]) act_n++;
      if (done[0]) begin done_n++; done_at = k; end
      if (active[1] || done[1] || out[31:16] != 16'h0) ch1_bad = 1;
    end
    n_cmp++;
    if (act_n != 5) begin n_err++; $display("FAIL burst_active_len: got %0d want 5", act_n); end
    n_cmp++;
    if (done_n != 1 || done_at != 5) begin
      n_err++; $display("FAIL burst_done: got %0d pulses at edge %0d want 1 at edge 5", done_n, done_at);
    end
    n_cmp++;
    if (ch1_bad) begin n_err++; $display("FAIL burst_ch1_quiet: got activity want none"); end
  endtask

  task automatic test_retrigger;
    int act_n = 0, done_n = 0, done_at = -1;
    for (int k = 0; k < 10; k++) begin
      edge_drive((k == 0 || k == 2) ? 2'b01 : 2'b00, 12'd4, 1'b1, 3'd0, 1'b0, '0);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL retrigger[%0d]: got %h want %h", k, obs, e);
      end
      if (active[0]) act_n++;
      if (done[0]) begin done_n++; done_at = k; end
    end
    n_cmp++;
    if (act_n != 6 || done_n != 1 || done_at != 6) begin
      n_err++;
      $display("FAIL retrigger_len: got active %0d done %0d@%0d want 6 / 1@6", act_n, done_n, done_at);
    end
  endtask

  task automatic test_zero_len;
    int act_n = 0, done_n = 0, done_at = -1;
    for (int k = 0; k < 7; k++) begin
      edge_drive((k <= 2) ? 2'b01 : 2'b00, (k == 1) ? 12'd3 : 12'd0, 1'b1, 3'd0, 1'b0, '0);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL zero_len[%0d]: got %h want %h", k, obs, e);
      end
      if (active[0]) act_n++;
      if (done[0]) begin done_n++; done_at = k; end
    end
    n_cmp++;
    if (act_n != 3 || done_n != 1 || done_at != 4) begin
      n_err++;
      $display("FAIL zero_len_count: got active %0d done %0d@%0d want 3 / 1@4", act_n, done_n, done_at);
    end
  endtask

  task automatic test_seed_load;
    edge_drive('0, '0, 1'b0, 3'd0, 1'b1, 24'hFFFFFF);
    e = sb.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL seed_load: got %h want %h", obs, e); end
    n_cmp++;
    if (out !== 32'hFEFF_0000) begin
      n_err++; $display("FAIL seed_fixup: got %h want %h", out, 32'hFEFF_0000);
    end
    edge_drive('0, '0, 1'b0, 3'd0, 1'b0, '0);
    e = sb.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL seed_step: got %h want %h", obs, e); end
    // step24 of zero shifts a 1 into the bit that ends up as the MSB
    n_cmp++;
    if (out[15] !== 1'b1) begin n_err++; $display("FAIL seed_not_stuck: got %b want 1", out[15]); end
  endtask

  task automatic test_level;
    bit sign_bad = 0;
    for (int k = 0; k < 20; k++) begin
      edge_drive('0, '0, 1'b0, 3'd3, 1'b0, '0);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL level[%0d]: got %h want %h", k, obs, e);
      end
      for (int i = 0; i < CH; i++)
        if (out[i*W+15 -: 4] != 4'h0 && out[i*W+15 -: 4] != 4'hF) sign_bad = 1;
    end
    n_cmp++;
    if (sign_bad) begin n_err++; $display("FAIL level_sign_ext: got unextended sign want extended"); end
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 3; k++) begin
      edge_drive(k == 0 ? 2'b11 : 2'b00, 12'd10, 1'b1, 3'd0, 1'b0, '0);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL async_pre[%0d]: got %h want %h", k, obs, e);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 36'h0) begin
      n_err++; $display("FAIL async_reset_clear: got %h want %h", obs, 36'h0);
    end
    @(posedge lrck); #1;
    rst = 1'b0;
    m_reset();
    for (int k = 0; k < 5; k++) begin
      edge_drive('0, '0, 1'b0, 3'd0, 1'b0, '0);
      e = sb.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL async_post[%0d]: got %h want %h", k, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_retrigger();
    test_zero_len();
    test_seed_load();
    test_level();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
